uart_apb_sequencer: RTL and testbench
=====================================

UART_APB_SEQUENCER -- requirements
Module: uart_apb_sequencer

Interface
REQ-001 Parameter BAUD_VAL, default 13'd1: 13-bit baud divisor written to the UART at init.
REQ-002 Parameter CFG_BIT8, default 1'b1: 8-bit data mode bit written to CTRL2.
REQ-003 Parameter CFG_PARITY_EN, default 1'b0; parameter CFG_ODD_N_EVEN, default 1'b0: parity settings written to CTRL2.
REQ-004 One clock and an asynchronous active-low reset: PCLK in 1 system clock; PRESETN in 1 async active-low reset.
REQ-005 APB master signals: PADDR out 5; PSEL out 1; PENABLE out 1; PWRITE out 1; PWDATA out 8; PRDATA in 8; PREADY in 1; PSLVERR in 1.
REQ-006 UART sideband: TXRDY in 1 (TX holding register empty); RXRDY in 1 (RX byte available).
REQ-007 tx_valid in 1, tx_data in 8, tx_ready out 1: byte-to-send handshake.
REQ-008 rx_valid out 1, rx_data out 8, rx_ready in 1: received-byte handshake.
REQ-009 init_done out 1 (config complete); bus_err out 1 (sticky PSLVERR); err_clr in 1 (clears bus_err).

Function
REQ-010 Register map: TXDATA 5'h00, RXDATA 5'h04, CTRL1 5'h08, CTRL2 5'h0C, STATUS 5'h10.
REQ-011 FSM states: INIT_C1, INIT_C2, IDLE, SETUP, ACCESS.
REQ-012 After reset, write CTRL1 = BAUD_VAL[7:0], then CTRL2 = {BAUD_VAL[12:8], CFG_ODD_N_EVEN, CFG_PARITY_EN, CFG_BIT8}; init_done rises the cycle after CTRL2 completes and stays high until reset.
REQ-013 Every transfer: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable from SETUP through completion.
REQ-014 PSEL, PENABLE low in IDLE; no back-to-back transfers without one IDLE cycle.
REQ-015 TX job eligible when tx_valid=1, TXRDY=1, TX holdoff clear; RX job eligible when RXRDY=1 and rx_valid=0.
REQ-016 Both eligible: job not served last wins (round-robin, last-served flag resets to TX so RX wins first).
REQ-017 TX write of tx_data to TXDATA; tx_ready pulses high exactly one cycle, the completion cycle (PREADY=1 in ACCESS); tx_data must be stable while tx_valid=1.
REQ-018 After each TX completion, TXRDY ignored for 2 cycles (holdoff) to cover sideband lag.
REQ-019 RX read of RXDATA; PRDATA captured at completion into rx_data, rx_valid set next cycle, held until rx_valid&rx_ready.
REQ-020 rx_valid=1 blocks further RX reads (backpressure); UART overflow is then permitted.
REQ-021 PSLVERR=1 at any completion sets bus_err; transfer still counts as complete; err_clr clears bus_err unless a PSLVERR completion occurs same cycle (set wins).
REQ-022 No jobs issued before init_done=1; tx_valid/RXRDY ignored during INIT states.

Reset
REQ-023 PRESETN low asynchronously forces state INIT_C1 and all outputs 0 (PADDR, PWDATA, PSEL, PENABLE, PWRITE, tx_ready, rx_valid, rx_data, init_done, bus_err), holdoff 0, last-served = TX.
REQ-024 Reset mid-transfer abandons it; init sequence restarts on release; in-flight rx byte is lost.

Configuration
REQ-025 Macro UART_SEQ_STATUS_POLL_EN defined: TXRDY/RXRDY inputs ignored; in IDLE after init, a STATUS read is issued; PRDATA[0] and PRDATA[1] latch as TXRDY/RXRDY for the eligibility of REQ-015; the latched flags are used for one arbitration decision, then re-polled; TX holdoff unused.
REQ-026 Macro undefined: sideband inputs used directly; no STATUS reads ever issued.

Structure
REQ-027 Shared package uart_seq_pkg: register address constants, FSM state enum, job-type enum (JOB_TX, JOB_RX, JOB_STAT).
REQ-028 One sub-module, uart_seq_arb: 2-requester round-robin picker with last-served flag; the APB FSM stays in the top module.

Verification
REQ-029 Reset release, BAUD_VAL=13'h1A5, PREADY=1 -> writes 08<=A5, 0C<={5'h01,0,0,1}=8'h09; init_done high cycle after second completion.
REQ-030 tx_valid=1, tx_data=8'h55, TXRDY=1, PREADY low 3 cycles -> ACCESS held 4 cycles, PWDATA=55 throughout, single tx_ready pulse on completion.
REQ-031 TXRDY=1, RXRDY=1, tx_valid=1 continuous -> order RX, TX, RX, TX; rx_data equals PRDATA of each RX read.
REQ-032 rx_valid=1, rx_ready=0, RXRDY=1 for 20 cycles -> no read of 5'h04 issued; rx_ready=1 -> next RX read after one IDLE cycle.
REQ-033 PSLVERR=1 on a TX write -> bus_err=1 and tx_ready pulses; err_clr=1 -> bus_err=0 next cycle; PRESETN low mid-ACCESS -> PSEL=0 immediately.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared constants and types for the UART APB sequencer: register map,
// sequencer FSM states and job kinds.
package uart_seq_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    // Cycles TXRDY is ignored after a TX write, covering sideband lag
    localparam logic [1:0] TX_HOLDOFF_CYC = 2'd2;

    typedef enum logic [2:0] {
        INIT_C1,
        INIT_C2,
        IDLE,
        SETUP,
        ACCESS
    } seq_state_e;

    typedef enum logic [1:0] {
        JOB_TX,
        JOB_RX,
        JOB_STAT
    } job_e;

endpackage

// File: rtl/uart_seq_arb.sv
// Two-requester round-robin picker (TX vs RX). The last-served flag resets
// to TX, so RX wins the first contested decision.
module uart_seq_arb (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_tx,
    input  logic i_req_rx,
    input  logic i_take,
    output logic o_gnt_tx,
    output logic o_gnt_rx
);

    logic r_last_rx;

    always_comb begin
        o_gnt_rx = i_req_rx && (!i_req_tx || !r_last_rx);
        o_gnt_tx = i_req_tx && !o_gnt_rx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last_rx <= 1'b0;
        else if (i_take && (o_gnt_tx || o_gnt_rx))
            r_last_rx <= o_gnt_rx;
    end

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a UART then shuttles TX/RX bytes through it.
// Optional UART_SEQ_STATUS_POLL_EN: derive TX/RX readiness from STATUS reads.
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [12:0] BAUD_VAL       = 13'd1,
    parameter logic        CFG_BIT8       = 1'b1,
    parameter logic        CFG_PARITY_EN  = 1'b0,
    parameter logic        CFG_ODD_N_EVEN = 1'b0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       init_done,
    output logic       bus_err,
    input  logic       err_clr
);

    seq_state_e r_state, w_state_nxt;
    job_e       r_job, w_job_nxt;
    logic [4:0] r_paddr, w_paddr_nxt;
    logic [7:0] r_pwdata, w_pwdata_nxt;
    logic       r_pwrite, w_pwrite_nxt;
    logic       w_launch, w_take;
    logic       r_init_done, r_bus_err, r_rx_valid;
    logic [7:0] r_rx_data;
    logic       w_done, w_tx_done, w_rx_done;
    logic       w_tx_elig, w_rx_elig, w_gnt_tx, w_gnt_rx;

    assign w_done    = (r_state == ACCESS) && PREADY;
    assign w_tx_done = w_done && r_init_done && (r_job == JOB_TX);
    assign w_rx_done = w_done && r_init_done && (r_job == JOB_RX);

`ifdef UART_SEQ_STATUS_POLL_EN
    logic r_stat_vld, r_stat_tx, r_stat_rx;

    assign w_tx_elig = r_init_done && r_stat_vld && r_stat_tx && tx_valid;
    assign w_rx_elig = r_init_done && r_stat_vld && r_stat_rx && !r_rx_valid;

    // Polled flags are good for exactly one IDLE decision
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_stat_vld <= 1'b0;
            r_stat_tx  <= 1'b0;
            r_stat_rx  <= 1'b0;
        end else if (w_done && r_init_done && (r_job == JOB_STAT)) begin
            r_stat_vld <= 1'b1;
            r_stat_tx  <= PRDATA[0];
            r_stat_rx  <= PRDATA[1];
        end else if (r_state == IDLE && r_stat_vld) begin
            r_stat_vld <= 1'b0;
        end
    end
`else
    logic [1:0] r_holdoff;

    assign w_tx_elig = r_init_done && tx_valid && TXRDY && (r_holdoff == 2'd0);
    assign w_rx_elig = r_init_done && RXRDY && !r_rx_valid;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            r_holdoff <= 2'd0;
        else if (w_tx_done)
            r_holdoff <= TX_HOLDOFF_CYC;
        else if (r_holdoff != 2'd0)
            r_holdoff <= r_holdoff - 2'd1;
    end
`endif

    uart_seq_arb u_arb (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETN),
        .i_req_tx (w_tx_elig),
        .i_req_rx (w_rx_elig),
        .i_take   (w_take),
        .o_gnt_tx (w_gnt_tx),
        .o_gnt_rx (w_gnt_rx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_job_nxt    = r_job;
        w_paddr_nxt  = r_paddr;
        w_pwdata_nxt = r_pwdata;
        w_pwrite_nxt = r_pwrite;
        w_launch     = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            INIT_C1: begin
                w_launch     = 1'b1;
                w_paddr_nxt  = ADDR_CTRL1;
                w_pwdata_nxt = BAUD_VAL[7:0];
                w_pwrite_nxt = 1'b1;
                w_state_nxt  = SETUP;
            end
            INIT_C2: begin
                w_launch     = 1'b1;
                w_paddr_nxt  = ADDR_CTRL2;
                w_pwdata_nxt = {BAUD_VAL[12:8], CFG_ODD_N_EVEN, CFG_PARITY_EN, CFG_BIT8};
                w_pwrite_nxt = 1'b1;
                w_state_nxt  = SETUP;
            end
            IDLE: begin
`ifdef UART_SEQ_STATUS_POLL_EN
                if (r_init_done && !r_stat_vld) begin
                    w_launch     = 1'b1;
                    w_job_nxt    = JOB_STAT;
                    w_paddr_nxt  = ADDR_STATUS;
                    w_pwrite_nxt = 1'b0;
                    w_state_nxt  = SETUP;
                end else
`endif
                if (w_gnt_rx) begin
                    w_launch     = 1'b1;
                    w_take       = 1'b1;
                    w_job_nxt    = JOB_RX;
                    w_paddr_nxt  = ADDR_RXDATA;
                    w_pwrite_nxt = 1'b0;
                    w_state_nxt  = SETUP;
                end else if (w_gnt_tx) begin
                    w_launch     = 1'b1;
                    w_take       = 1'b1;
                    w_job_nxt    = JOB_TX;
                    w_paddr_nxt  = ADDR_TXDATA;
                    w_pwdata_nxt = tx_data;
                    w_pwrite_nxt = 1'b1;
                    w_state_nxt  = SETUP;
                end
            end
            SETUP:  w_state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (!r_init_done && r_paddr == ADDR_CTRL1)
                        w_state_nxt = INIT_C2;
                    else
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = INIT_C1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state  <= INIT_C1;
            r_job    <= JOB_TX;
            r_paddr  <= 5'h00;
            r_pwdata <= 8'h00;
            r_pwrite <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_job    <= w_job_nxt;
                r_paddr  <= w_paddr_nxt;
                r_pwdata <= w_pwdata_nxt;
                r_pwrite <= w_pwrite_nxt;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_init_done <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
        end else begin
            if (w_done && !r_init_done && r_paddr == ADDR_CTRL2)
                r_init_done <= 1'b1;
            // A faulting completion beats a same-cycle clear
            if (w_done && PSLVERR)
                r_bus_err <= 1'b1;
            else if (err_clr)
                r_bus_err <= 1'b0;
            if (w_rx_done) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= PRDATA;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PSEL      = (r_state == SETUP) || (r_state == ACCESS);
    assign PENABLE   = (r_state == ACCESS);
    assign tx_ready  = w_tx_done;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign init_done = r_init_done;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: init writes, TX wait states,
// RX/TX round-robin, RX backpressure, bus errors and mid-transfer reset.
module tb_uart_apb_sequencer;

    logic       PCLK, PRESETN;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR, TXRDY, RXRDY;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0] tx_data, rx_data;
    logic       init_done, bus_err, err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    uart_apb_sequencer #(.BAUD_VAL(13'h1A5)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .TXRDY(TXRDY), .RXRDY(RXRDY),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .init_done(init_done), .bus_err(bus_err), .err_clr(err_clr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge where a SETUP phase is visible
    task automatic wait_setup(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(PSEL && !PENABLE) && n < 60);
        if (!(PSEL && !PENABLE))
            chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [4:0] exp_addr [4];
        logic [7:0] rd_vals  [4];
        int         n_psel;

        PRESETN = 1'b0; PRDATA = 8'h00; PREADY = 1'b1; PSLVERR = 1'b0;
        TXRDY = 1'b0; RXRDY = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rx_valid", rx_valid, 0);

        // Init: CTRL1 <= A5, CTRL2 <= 09
        PRESETN = 1'b1;
        wait_setup("init1");
        chk("init1_addr", PADDR, 5'h08);
        chk("init1_data", PWDATA, 8'hA5);
        chk("init1_write", PWRITE, 1);
        @(negedge PCLK);
        chk("init1_penable", PENABLE, 1);
        @(negedge PCLK);
        chk("init_gap_psel", PSEL, 0);
        wait_setup("init2");
        chk("init2_addr", PADDR, 5'h0C);
        chk("init2_data", PWDATA, 8'h09);
        @(negedge PCLK);
        chk("init2_done_early", init_done, 0);
        @(negedge PCLK);
        chk("init_done", init_done, 1);
        chk("init_after_psel", PSEL, 0);

        // TX with three wait states
        repeat (2) @(negedge PCLK);
        tx_valid = 1'b1; tx_data = 8'h55; TXRDY = 1'b1; PREADY = 1'b0;
        wait_setup("tx1");
        chk("tx1_addr", PADDR, 5'h00);
        chk("tx1_data", PWDATA, 8'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("tx1_wait_penable", PENABLE, 1);
            chk("tx1_wait_data", PWDATA, 8'h55);
            chk("tx1_wait_ready", tx_ready, 0);
        end
        @(negedge PCLK);
        PREADY = 1'b1; tx_valid = 1'b0;
        #1;
        chk("tx1_last_penable", PENABLE, 1);
        chk("tx1_ready_pulse", tx_ready, 1);
        @(negedge PCLK);
        chk("tx1_ready_drop", tx_ready, 0);
        chk("tx1_idle_psel", PSEL, 0);

        // Round-robin: RX, TX, RX, TX
        repeat (4) @(negedge PCLK);
        exp_addr = '{5'h04, 5'h00, 5'h04, 5'h00};
        rd_vals  = '{8'hC3, 8'h00, 8'h5A, 8'h00};
        tx_valid = 1'b1; tx_data = 8'hAA; RXRDY = 1'b1; rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_setup("rr");
            chk("rr_addr", PADDR, exp_addr[k]);
            if (exp_addr[k] == 5'h04) begin
                chk("rr_rx_write", PWRITE, 0);
                PRDATA = rd_vals[k];
                @(negedge PCLK);
                @(negedge PCLK);
                chk("rr_rx_valid", rx_valid, 1);
                chk("rr_rx_data", rx_data, rd_vals[k]);
            end else begin
                chk("rr_tx_data", PWDATA, 8'hAA);
                @(negedge PCLK);
                if (k == 3) begin
                    tx_valid = 1'b0; RXRDY = 1'b0;
                end
                #1;
                chk("rr_tx_ready", tx_ready, 1);
            end
        end

        // RX backpressure: no RXDATA read while rx_valid is held
        repeat (3) @(negedge PCLK);
        rx_ready = 1'b0; RXRDY = 1'b1;
        wait_setup("bp");
        chk("bp_addr", PADDR, 5'h04);
        PRDATA = 8'h81;
        @(negedge PCLK);
        @(negedge PCLK);
        n_psel = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL) n_psel++;
        end
        chk("bp_no_read", n_psel, 0);
        chk("bp_rx_valid_held", rx_valid, 1);
        chk("bp_rx_data", rx_data, 8'h81);
        rx_ready = 1'b1;
        @(negedge PCLK);
        chk("bp_idle_psel", PSEL, 0);
        chk("bp_rx_valid_clr", rx_valid, 0);
        @(negedge PCLK);
        chk("bp_resume_setup", PSEL && !PENABLE, 1);
        chk("bp_resume_addr", PADDR, 5'h04);
        RXRDY = 1'b0; PRDATA = 8'h7E;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("bp_resume_data", rx_data, 8'h7E);

        // PSLVERR on a TX write, then clear
        repeat (3) @(negedge PCLK);
        tx_valid = 1'b1; tx_data = 8'h12; PSLVERR = 1'b1;
        wait_setup("err");
        chk("err_addr", PADDR, 5'h00);
        @(negedge PCLK);
        tx_valid = 1'b0;
        #1;
        chk("err_tx_ready", tx_ready, 1);
        @(negedge PCLK);
        PSLVERR = 1'b0;
        chk("err_set", bus_err, 1);
        @(negedge PCLK);
        chk("err_sticky", bus_err, 1);
        err_clr = 1'b1;
        @(negedge PCLK);
        chk("err_cleared", bus_err, 0);

        // Set beats clear when both land together
        tx_valid = 1'b1; tx_data = 8'h34; PSLVERR = 1'b1;
        wait_setup("err2");
        @(negedge PCLK);
        tx_valid = 1'b0;
        @(negedge PCLK);
        PSLVERR = 1'b0;
        chk("err_set_wins", bus_err, 1);
        @(negedge PCLK);
        chk("err_clr_after", bus_err, 0);
        err_clr = 1'b0;

        // Reset in the middle of ACCESS
        repeat (3) @(negedge PCLK);
        tx_valid = 1'b1; tx_data = 8'h99; PREADY = 1'b0;
        wait_setup("mrst");
        @(negedge PCLK);
        chk("mrst_access", PENABLE, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("mrst_psel", PSEL, 0);
        chk("mrst_penable", PENABLE, 0);
        chk("mrst_paddr", PADDR, 0);
        chk("mrst_init_done", init_done, 0);
        chk("mrst_rx_data", rx_data, 0);
        @(negedge PCLK);
        tx_valid = 1'b0; PREADY = 1'b1;
        PRESETN = 1'b1;
        wait_setup("mrst_init");
        chk("mrst_restart_addr", PADDR, 5'h08);
        chk("mrst_restart_data", PWDATA, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
